// File: rtl/rr_mux2_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rr_mux2_arb_pkg
// Brief  : Shared types, constants and sizing helpers for rr_mux2_arb.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package rr_mux2_arb_pkg;

    typedef logic src_t;

    localparam src_t SRC0 = 1'b0;
    localparam src_t SRC1 = 1'b1;

    // Burst counter must be able to hold the value BURST itself.
    function automatic int cnt_w(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux2_1.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : mux2_1
// Brief  : Single-bit 2:1 select cell (S=0 -> D0, S=1 -> D1).
// Rev    : 1.0
// ----------------------------------------------------------------------------
module mux2_1 (
    input  logic i_d0,
    input  logic i_d1,
    input  logic i_s,
    output logic o_y
);

    assign o_y = i_s ? i_d1 : i_d0;

endmodule
`default_nettype wire

// File: rtl/rr_mux2_grant.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rr_mux2_grant
// Brief  : Round-robin owner/burst tracking and load-qualified grant/ready.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module rr_mux2_grant
    import rr_mux2_arb_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d0_valid,
    input  logic i_d1_valid,
    input  logic i_load,
    output src_t o_grant,
    output logic o_grant_valid,
    output logic o_d0_ready,
    output logic o_d1_ready
);

    localparam int            CW      = cnt_w(BURST);
    localparam logic [CW-1:0] c_burst = CW'(BURST);
    localparam logic [CW-1:0] c_one   = CW'(1);

    src_t          r_owner;
    logic [CW-1:0] r_cnt;
    logic          w_take;

    // Owner keeps the bus under contention until it has used its full burst.
    always_comb begin
        o_grant = SRC0;
        if (i_d0_valid && i_d1_valid) begin
            o_grant = (r_cnt == c_burst) ? ~r_owner : r_owner;
        end else if (i_d1_valid) begin
            o_grant = SRC1;
        end
    end

    assign o_grant_valid = i_d0_valid | i_d1_valid;
    assign w_take        = !rst & i_load & o_grant_valid;
    assign o_d0_ready    = w_take & (o_grant == SRC0);
    assign o_d1_ready    = w_take & (o_grant == SRC1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= SRC0;
            r_cnt   <= '0;
        end else if (w_take) begin
            if (o_grant == r_owner) begin
                if (r_cnt != c_burst) begin
                    r_cnt <= r_cnt + c_one;
                end
            end else begin
                r_owner <= o_grant;
                r_cnt   <= c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_mux2_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rr_mux2_arb
// Brief  : Two-input round-robin arbiter with bounded bursts and a registered
//          valid/ready output stage.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module rr_mux2_arb
    import rr_mux2_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic             d0_valid,
    output logic             d0_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic             d1_valid,
    output logic             d1_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_src
);

    localparam logic [0:0] c_empty = 1'b0;
    localparam logic [0:0] c_full  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_y;
    src_t             r_y_src;

    logic             w_load;
    logic             w_take;
    logic             w_grant_valid;
    src_t             w_grant;
    logic [WIDTH-1:0] w_mux;

    // The register can take a word when empty or when its word leaves now.
    assign w_load = (r_state == c_empty) | y_ready;
    assign w_take = !rst & w_load & w_grant_valid;

    rr_mux2_grant #(
        .BURST (BURST)
    ) u_grant (
        .clk           (clk),
        .rst           (rst),
        .i_d0_valid    (d0_valid),
        .i_d1_valid    (d1_valid),
        .i_load        (w_load),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid),
        .o_d0_ready    (d0_ready),
        .o_d1_ready    (d1_ready)
    );

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_mux
            mux2_1 u_mux (
                .i_d0 (d0[i]),
                .i_d1 (d1[i]),
                .i_s  (w_grant),
                .o_y  (w_mux[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_empty;
            r_y     <= '0;
            r_y_src <= SRC0;
        end else begin
            case (r_state)
                c_empty: begin
                    if (w_take) begin
                        r_state <= c_full;
                        r_y     <= w_mux;
                        r_y_src <= w_grant;
                    end
                end
                default: begin
                    if (w_take) begin
                        r_y     <= w_mux;
                        r_y_src <= w_grant;
                    end else if (y_ready) begin
                        r_state <= c_empty;
                    end
                end
            endcase
        end
    end

    assign y       = r_y;
    assign y_valid = (r_state == c_full);
    assign y_src   = r_y_src;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux2_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_rr_mux2_arb
// Brief  : Self-checking bench for rr_mux2_arb (BURST=4 and BURST=1 instances).
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_rr_mux2_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0, d1;
    logic       d0_valid, d1_valid, y_ready;

    logic [7:0] a_y, b_y;
    logic       a_y_valid, b_y_valid, a_y_src, b_y_src;
    logic       a_d0_ready, a_d1_ready, b_d0_ready, b_d1_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_mux2_arb #(.WIDTH(8), .BURST(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .d0(d0), .d0_valid(d0_valid), .d0_ready(a_d0_ready),
        .d1(d1), .d1_valid(d1_valid), .d1_ready(a_d1_ready),
        .y(a_y), .y_valid(a_y_valid), .y_ready(y_ready), .y_src(a_y_src)
    );

    rr_mux2_arb #(.WIDTH(8), .BURST(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .d0(d0), .d0_valid(d0_valid), .d0_ready(b_d0_ready),
        .d1(d1), .d1_valid(d1_valid), .d1_ready(b_d1_ready),
        .y(b_y), .y_valid(b_y_valid), .y_ready(y_ready), .y_src(b_y_src)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: last winner plus length of its current winning streak.
    logic       m_valid  [2];
    logic [7:0] m_y      [2];
    logic       m_src    [2];
    logic       m_last   [2];
    int         m_streak [2];
    int         m_burst  [2] = '{4, 1};

    function automatic logic m_gnt(input int k);
        if (d0_valid && d1_valid)
            return (m_streak[k] >= m_burst[k]) ? ~m_last[k] : m_last[k];
        return d1_valid;
    endfunction

    function automatic logic m_acc(input int k);
        return !rst && (!m_valid[k] || y_ready) && (d0_valid || d1_valid);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_valid[k]  <= 1'b0;
                m_y[k]      <= 8'h00;
                m_src[k]    <= 1'b0;
                m_last[k]   <= 1'b0;
                m_streak[k] <= 0;
            end else if (m_acc(k)) begin
                m_valid[k] <= 1'b1;
                m_y[k]     <= m_gnt(k) ? d1 : d0;
                m_src[k]   <= m_gnt(k);
                if (m_gnt(k) == m_last[k]) begin
                    m_streak[k] <= m_streak[k] + 1;
                end else begin
                    m_last[k]   <= m_gnt(k);
                    m_streak[k] <= 1;
                end
            end else if (y_ready) begin
                m_valid[k] <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            #4;
            for (int k = 0; k < 2; k++) begin
                logic       gv, gs, g0, g1, e0, e1;
                logic [7:0] gy;
                gv = (k == 0) ? a_y_valid  : b_y_valid;
                gy = (k == 0) ? a_y        : b_y;
                gs = (k == 0) ? a_y_src    : b_y_src;
                g0 = (k == 0) ? a_d0_ready : b_d0_ready;
                g1 = (k == 0) ? a_d1_ready : b_d1_ready;
                e0 = m_acc(k) && (m_gnt(k) == 1'b0);
                e1 = m_acc(k) && (m_gnt(k) == 1'b1);
                chk($sformatf("model_y_valid[%0d]", k), gv, m_valid[k]);
                chk($sformatf("model_y[%0d]", k), gy, m_y[k]);
                chk($sformatf("model_y_src[%0d]", k), gs, m_src[k]);
                chk($sformatf("model_d0_ready[%0d]", k), g0, e0);
                chk($sformatf("model_d1_ready[%0d]", k), g1, e1);
            end
        end
    end

    // Directed scenarios with literal expectations, then random traffic.
    initial begin
        logic [0:11] exp_a;
        exp_a = 12'b0000_1111_0000;

        rst = 1'b1; d0_valid = 1'b1; d1_valid = 1'b1; y_ready = 1'b1;
        d0 = 8'h33; d1 = 8'h44;

        repeat (2) begin
            @(negedge clk); #2;
            chk("rst_y_valid", a_y_valid, 1'b0);
            chk("rst_d0_ready", a_d0_ready, 1'b0);
            chk("rst_d1_ready", a_d1_ready, 1'b0);
        end
        rst = 1'b0;

        // Continuous contention
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #2;
            chk("cont_a_valid", a_y_valid, 1'b1);
            chk($sformatf("cont_a_src[%0d]", i), a_y_src, exp_a[i]);
            chk($sformatf("cont_b_src[%0d]", i), b_y_src, (i % 2) != 0);
            d0 = 8'($urandom); d1 = 8'($urandom);
        end

        // Solo stream from source 1
        d0_valid = 1'b0; d1_valid = 1'b1; d1 = 8'h10;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #2;
            chk("solo_y", a_y, 8'h10 + 8'(i));
            chk("solo_src", a_y_src, 1'b1);
            d1 = 8'h11 + 8'(i);
        end

        // Backpressure holding 0xA5
        d0_valid = 1'b1; d1_valid = 1'b0; d0 = 8'hA5;
        @(negedge clk); #2;
        chk("bp_load_y", a_y, 8'hA5);
        y_ready = 1'b0; d1_valid = 1'b1; d0 = 8'h5A; d1 = 8'h3C;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_y", a_y, 8'hA5);
            chk("bp_hold_valid", a_y_valid, 1'b1);
            chk("bp_d0_ready", a_d0_ready, 1'b0);
            chk("bp_d1_ready", a_d1_ready, 1'b0);
            if (i < 2) begin
                @(negedge clk); #3;
            end
        end
        y_ready = 1'b1;
        @(negedge clk); #2;
        chk("bp_release_valid", a_y_valid, 1'b1);
        chk("bp_release_y", a_y, 8'h5A);
        chk("bp_release_src", a_y_src, 1'b0);

        // Reset in the middle of a source-1 burst
        d0_valid = 1'b0; d1_valid = 1'b1; d1 = 8'h77;
        repeat (2) begin
            @(negedge clk); #2;
            chk("mid_burst_src", a_y_src, 1'b1);
        end
        rst = 1'b1; d0_valid = 1'b1;
        @(negedge clk); #2;
        chk("mid_rst_a_valid", a_y_valid, 1'b0);
        chk("mid_rst_b_valid", b_y_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk); #2;
        chk("post_rst_a_src", a_y_src, 1'b0);
        chk("post_rst_b_src", b_y_src, 1'b0);
        chk("post_rst_a_valid", a_y_valid, 1'b1);
        @(negedge clk); #2;
        chk("post_rst_a_src2", a_y_src, 1'b0);
        chk("post_rst_b_src2", b_y_src, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 59) == 0);
            d0_valid = ($urandom_range(0, 3) != 0);
            d1_valid = ($urandom_range(0, 3) != 0);
            y_ready  = ($urandom_range(0, 3) != 0);
            d0       = 8'($urandom);
            d1       = 8'($urandom);
        end

        @(negedge clk); #6;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
